// File: rtl/xadc_avg_sampler.sv
// XADC DRP reader: fetches each end-of-conversion result and publishes a
// per-channel average of 2^AVG_LOG2 samples, with overrun/timeout flags.
module xadc_avg_sampler #(
  parameter int         CHANNELS  = 4,
  parameter logic [6:0] BASE_ADDR = 7'h10,
  parameter int         AVG_LOG2  = 2,
  parameter int         TIMEOUT   = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   eoc_in,
  input  logic [4:0]             channel_in,
  input  logic                   drdy_in,
  input  logic [15:0]            do_in,
  output logic                   den_out,
  output logic [6:0]             daddr_out,
  output logic [CHANNELS*12-1:0] ch_value,
  output logic                   sample_valid,
  output logic [3:0]             sample_ch,
  input  logic                   clear_flags,
  output logic                   overrun,
  output logic                   timeout_err
);

  localparam int AW     = 12 + AVG_LOG2;
  localparam int CW     = AVG_LOG2 + 1;
  localparam int TW     = $clog2(TIMEOUT + 1);
  localparam int NSAMP  = 1 << AVG_LOG2;

  typedef enum logic [1:0] {S_IDLE, S_READ, S_WAIT, S_ACC} state_t;

  state_t          state_reg;
  logic [3:0]      idx_reg;
  logic [11:0]     sample_reg;
  logic [TW-1:0]   wait_cnt_reg;

  logic [7:0]          ch_ext;
  logic [7:0]          ch_off;
  logic                ch_in_range;
  logic [CHANNELS-1:0] pub_hit;
  logic                unused_low_bits;

  // The low nibble of the DRP word carries no conversion data.
  assign unused_low_bits = ^do_in[3:0];

  assign ch_ext      = {3'b000, channel_in};
  assign ch_off      = ch_ext - {1'b0, BASE_ADDR};
  assign ch_in_range = (ch_ext >= {1'b0, BASE_ADDR}) && (ch_off < 8'(CHANNELS));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= S_IDLE;
      idx_reg      <= '0;
      sample_reg   <= '0;
      wait_cnt_reg <= '0;
      den_out      <= 1'b0;
      daddr_out    <= '0;
      sample_valid <= 1'b0;
      sample_ch    <= '0;
      overrun      <= 1'b0;
      timeout_err  <= 1'b0;
    end else begin
      den_out      <= 1'b0;
      sample_valid <= 1'b0;

      // Clear first so a same-cycle set event below takes precedence.
      if (clear_flags) begin
        overrun     <= 1'b0;
        timeout_err <= 1'b0;
      end
      if (eoc_in && (state_reg != S_IDLE))
        overrun <= 1'b1;

      case (state_reg)
        S_IDLE: begin
          if (eoc_in && ch_in_range) begin
            idx_reg   <= ch_off[3:0];
            daddr_out <= {2'b00, channel_in};
            den_out   <= 1'b1;
            state_reg <= S_READ;
          end
        end
        S_READ: begin
          wait_cnt_reg <= '0;
          state_reg    <= S_WAIT;
        end
        S_WAIT: begin
          if (drdy_in) begin
            sample_reg <= do_in[15:4];
            state_reg  <= S_ACC;
          end else if (wait_cnt_reg == TW'(TIMEOUT - 1)) begin
            timeout_err <= 1'b1;
            state_reg   <= S_IDLE;
          end else begin
            wait_cnt_reg <= wait_cnt_reg + TW'(1);
          end
        end
        S_ACC: begin
          state_reg <= S_IDLE;
          if (|pub_hit) begin
            sample_valid <= 1'b1;
            sample_ch    <= idx_reg;
          end
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  // Each channel owns its accumulator, sample count and published value.
  genvar gi;
  generate
    for (gi = 0; gi < CHANNELS; gi++) begin : g_ch
      logic [AW-1:0] acc_reg;
      logic [AW-1:0] acc_next;
      logic [CW-1:0] cnt_reg;
      logic [11:0]   value_reg;
      logic          sel;

      assign sel          = (state_reg == S_ACC) && (idx_reg == 4'(gi));
      assign acc_next     = acc_reg + AW'(sample_reg);
      assign pub_hit[gi]  = sel && (cnt_reg == CW'(NSAMP - 1));

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          acc_reg   <= '0;
          cnt_reg   <= '0;
          value_reg <= '0;
        end else if (sel) begin
          if (pub_hit[gi]) begin
            value_reg <= acc_next[AW-1:AVG_LOG2];
            acc_reg   <= '0;
            cnt_reg   <= '0;
          end else begin
            acc_reg <= acc_next;
            cnt_reg <= cnt_reg + CW'(1);
          end
        end
      end

      assign ch_value[gi*12 +: 12] = value_reg;
    end
  endgenerate

endmodule

// File: doc/xadc_avg_sampler.md
# xadc_avg_sampler

Parametrised XADC dynamic-reconfiguration-port (DRP) reader sitting between the XADC wizard instance and downstream consumers such as the PWM colour drivers. On every XADC end-of-conversion it reads the converted channel's result register, then averages 2^AVG_LOG2 samples per channel. It publishes a per-channel 12-bit averaged value plus a one-cycle update strobe. It replaces direct use of the raw `do_out` bus, adds multi-channel support, and detects overrun and DRP-timeout conditions.

## Interface
- `CHANNELS`, default 4: number of consecutive XADC channel addresses served (1..16).
- `BASE_ADDR`, default 7'h10: DRP address of channel index 0 (VAUX0). Channel k is at BASE_ADDR+k.
- `AVG_LOG2`, default 2: log2 of samples averaged per published value (0..6). 0 means pass-through.
- `TIMEOUT`, default 64: maximum cycles to wait for `drdy_in` after `den_out` (≥2).
- `clk`  in  1  system clock (100 MHz); also drives XADC `dclk_in`.
- `rst`  in  1  asynchronous, active-high reset.
- `eoc_in`  in  1  XADC end-of-conversion pulse.
- `channel_in`  in  5  XADC `channel_out`, valid while `eoc_in` is high.
- `drdy_in`  in  1  XADC DRP data ready.
- `do_in`  in  16  XADC DRP data. Result is `do_in[15:4]`.
- `den_out`  out  1  DRP enable, one-cycle pulse.
- `daddr_out`  out  7  DRP address.
- `ch_value`  out  CHANNELS*12  averaged results. Channel k occupies bits [12k+11:12k].
- `sample_valid`  out  1  one-cycle strobe when a channel value updates.
- `sample_ch`  out  4  index of the channel updated, valid with `sample_valid`.
- `clear_flags`  in  1  synchronous clear of the sticky flags.
- `overrun`  out  1  sticky: an EOC arrived while the block was busy.
- `timeout_err`  out  1  sticky: a DRP read got no `drdy_in` within TIMEOUT cycles.

## Operation
- FSM states:
  - IDLE: the only state in which `eoc_in` is accepted.
  - READ: `den_out`=1 for exactly one cycle.
  - WAIT: counting cycles until `drdy_in`.
  - ACC: accumulate the sample and possibly publish.
- IDLE: on `eoc_in`=1 with `channel_in` in [BASE_ADDR, BASE_ADDR+CHANNELS), latch index k = `channel_in`-BASE_ADDR and go to READ. Out-of-range channels are ignored, with no flag.
- READ: `den_out`=1 and `daddr_out`=BASE_ADDR+k, then go to WAIT. `daddr_out` holds its value until the next READ.
- WAIT: on `drdy_in`=1, register `do_in[15:4]` and go to ACC. If TIMEOUT cycles elapse with no `drdy_in`, set `timeout_err`, discard the read, and return to IDLE.
- ACC:
  - acc[k] += sample (width 12+AVG_LOG2, never overflows) and cnt[k] += 1.
  - When cnt[k] reaches 2^AVG_LOG2:
    - `ch_value[k]` ← acc[k] >> AVG_LOG2 (truncating).
    - acc[k] and cnt[k] are cleared.
    - `sample_valid`=1 and `sample_ch`=k on the next cycle.
  - Always return to IDLE.
- `eoc_in`=1 in READ, WAIT or ACC sets `overrun`. That conversion is dropped and the FSM is unaffected.
- `drdy_in` in IDLE, READ or ACC is ignored.
- `clear_flags`=1 clears `overrun` and `timeout_err` on the next edge. A set event in the same cycle wins: the flag stays 1.
- Per-channel accumulators are independent. Interleaved channels never mix.

## Timing
- Reset (async, any state) clears everything immediately:
  - FSM to IDLE.
  - `den_out`=0, `daddr_out`=0.
  - all `ch_value`=0, all acc/cnt=0.
  - `sample_valid`=0, `sample_ch`=0.
  - `overrun`=0, `timeout_err`=0.
- Reset mid-read abandons the transaction. A later stray `drdy_in` is ignored.
- Read sequence:
  - `eoc_in` sampled in IDLE at edge t.
  - `den_out` high during cycle t+1.
  - WAIT entered at t+2.
  - `drdy_in` sampled at edge d puts the FSM in ACC for cycle d+1.
- Publishing: `sample_valid`, `sample_ch` and the updated `ch_value[k]` are all visible in cycle d+2. The FSM is in IDLE in cycle d+2 and accepts an `eoc_in` there.
- Timeout: if `drdy_in` is absent through TIMEOUT WAIT cycles, IDLE and `timeout_err`=1 apply from the following cycle.
- An `eoc_in` coinciding with the ACC→IDLE edge is in ACC and counts as overrun.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Test plan
- **Reset values.** Assert `rst` asynchronously mid-WAIT → all outputs 0 within the same cycle. `drdy_in` one cycle after release → no `sample_valid`.
- **Pass-through.** AVG_LOG2=0, CHANNELS=4. Apply `eoc_in` with `channel_in`=5'h12 and `do_in`=16'hABC0 with `drdy_in` 3 cycles after `den_out`:
  - `daddr_out`=7'h12 on the `den_out` cycle.
  - `sample_valid` with `sample_ch`=2 and `ch_value[35:24]`=12'hABC, exactly 2 cycles after `drdy_in`.
- **Averaging and interleave.** AVG_LOG2=2. Four ch0 reads of 12'h100, 12'h200, 12'h300, 12'h401 interleaved with ch1 reads → `ch_value[11:0]`=12'h280 after the 4th ch0 read only. ch1 is unaffected until its own 4th read.
- **Overrun.** Pulse `eoc_in` while in WAIT → `overrun`=1. The in-flight read still completes correctly. `clear_flags` → 0. `clear_flags` in the same cycle as a new overrun → stays 1.
- **Timeout.** TIMEOUT=8, never assert `drdy_in` → `timeout_err`=1 after 8 WAIT cycles, FSM back in IDLE, and the next EOC is serviced normally with no accumulation from the failed read.
- **Out of range.** `channel_in`=5'h03 → no `den_out`, no flags set.
